// File: rtl/note_window.sv
// note_window: fixed pool of scrolling note slots with a 2-stage pixel query.
//
// Each slot ages by one on every beat48 tick, so its notes scroll from the
// right edge towards the left. Once a note has fully left the screen its slot
// is evicted. New notes enter through a valid/ready handshake and go into the
// lowest free slot. A pixel query returns whether any note covers (x, y), and
// the channel of the lowest-index covering slot.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   tick            one-cycle pulse per beat48 step (ages all slots)
//   in_valid/ready  insertion handshake; ready while a slot is free
//   in_note         row of the new note
//   in_channel      channel of the new note
//   in_duration     length in ticks (0 behaves as 1)
//   clear           invalidate every slot (beats tick and insert)
//   q_valid, x, y   pixel query strobe and coordinates
//   r_valid         result strobe, 2 cycles after q_valid
//   on, channel     hit flag and winning channel (both 0 unless on)
//   occupancy       registered count of valid slots

// One note slot: holds its state, computes its next state and its hit flag
// for the query currently presented.
module note_slot #(
  parameter int NOTE_BITS       = 4,
  parameter int BEAT_BITS       = 8,
  parameter int CHANNEL_BITS    = 2,
  parameter int ROW_HEIGHT      = 30,
  parameter int PIXELS_PER_TICK = 4,
  parameter int WINDOW_TICKS    = 160,
  parameter int CW              = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    tick,
  input  logic                    load,
  input  logic [NOTE_BITS-1:0]    load_note,
  input  logic [CHANNEL_BITS-1:0] load_channel,
  input  logic [BEAT_BITS-1:0]    load_duration,
  input  logic [CW-1:0]           qd,
  input  logic [CW-1:0]           qy,
  input  logic                    q_in_range,
  output logic                    valid,
  output logic                    valid_next,
  output logic [CHANNEL_BITS-1:0] channel,
  output logic                    hit
);
  localparam int AGE_W = BEAT_BITS + 1;
  // Eviction compare is two bits wider than the duration so that
  // duration + WINDOW_TICKS can never wrap.
  localparam int EW    = BEAT_BITS + 2;

  logic [NOTE_BITS-1:0] note;
  logic [BEAT_BITS-1:0] dur;
  logic [AGE_W-1:0]     age;
  logic [AGE_W-1:0]     age_inc;
  logic [AGE_W-1:0]     age_next;
  logic                 evict;
  logic [AGE_W-1:0]     lo;
  logic [CW-1:0]        lo_px;
  logic [CW-1:0]        hi_px;
  logic [CW-1:0]        row_lo;

  // Age saturates at all-ones; eviction always happens long before that.
  assign age_inc = (&age) ? age : age + AGE_W'(1);
  assign evict   = EW'(age_inc) >= (EW'(dur) + EW'(WINDOW_TICKS));

  // A freshly loaded slot was invalid, so it is never aged in the same cycle.
  always_comb begin
    valid_next = valid;
    age_next   = age;
    if (clear) begin
      valid_next = 1'b0;
    end else if (load) begin
      valid_next = 1'b1;
      age_next   = '0;
    end else if (tick && valid) begin
      age_next = age_inc;
      if (evict) valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      age     <= '0;
      note    <= '0;
      dur     <= '0;
      channel <= '0;
    end else begin
      valid <= valid_next;
      age   <= age_next;
      if (load && !clear) begin
        note    <= load_note;
        dur     <= load_duration;
        channel <= load_channel;
      end
    end
  end

  // The note's tail sits at (age - dur) ticks from the right edge, its head at
  // age ticks. qd is the distance of the pixel from the right edge.
  assign lo     = (age > AGE_W'(dur)) ? (age - AGE_W'(dur)) : '0;
  assign lo_px  = CW'(lo)   * CW'(PIXELS_PER_TICK);
  assign hi_px  = CW'(age)  * CW'(PIXELS_PER_TICK);
  assign row_lo = CW'(note) * CW'(ROW_HEIGHT);

  assign hit = valid && q_in_range &&
               (lo_px < qd) && (qd <= hi_px) &&
               (row_lo <= qy) && (qy < row_lo + CW'(ROW_HEIGHT));
endmodule

module note_window #(
  parameter int SCREEN_WIDTH       = 640,
  parameter int SCREEN_HEIGHT      = 480,
  parameter int SCREEN_WIDTH_BITS  = 10,
  parameter int SCREEN_HEIGHT_BITS = 9,
  parameter int SLOTS              = 16,
  parameter int NOTE_BITS          = 4,
  parameter int BEAT_BITS          = 8,
  parameter int PIXELS_PER_TICK    = 4,
  parameter int CHANNELS           = 4,
  localparam int CHANNEL_BITS      = $clog2(CHANNELS),
  localparam int OCC_W             = $clog2(SLOTS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NOTE_BITS-1:0]          in_note,
  input  logic [CHANNEL_BITS-1:0]       in_channel,
  input  logic [BEAT_BITS-1:0]          in_duration,
  input  logic                          clear,
  input  logic                          q_valid,
  input  logic [SCREEN_WIDTH_BITS-1:0]  x,
  input  logic [SCREEN_HEIGHT_BITS-1:0] y,
  output logic                          r_valid,
  output logic                          on,
  output logic [CHANNEL_BITS-1:0]       channel,
  output logic [OCC_W-1:0]              occupancy
);
  localparam int ROW_HEIGHT   = SCREEN_HEIGHT >> NOTE_BITS;
  localparam int WINDOW_TICKS = SCREEN_WIDTH / PIXELS_PER_TICK;
  localparam int CW           = 16;
  // vld_pipe[0] = stage-1 valid, vld_pipe[STAGES] = result valid.
  localparam int STAGES       = 1;

  logic [SLOTS-1:0]                   slot_valid;
  logic [SLOTS-1:0]                   slot_valid_next;
  logic [SLOTS-1:0]                   slot_hit;
  logic [SLOTS-1:0][CHANNEL_BITS-1:0] slot_chan;
  logic [SLOTS-1:0]                   ins_sel;
  logic                               ins_found;
  logic                               accept;
  logic [BEAT_BITS-1:0]               load_dur;
  logic [CW-1:0]                      qd;
  logic [CW-1:0]                      qy;
  logic                               q_in_range;
  logic [OCC_W-1:0]                   occ_next;
  logic [CHANNEL_BITS-1:0]            win_ch;

  logic [STAGES:0]                    vld_pipe;
  logic [SLOTS-1:0]                   hit_q;
  logic [CHANNEL_BITS-1:0]            win_ch_q;

  // in_ready is registered and only high while some slot is invalid, so an
  // accepted insert always finds a target in ins_sel.
  assign accept   = in_valid && in_ready;
  assign load_dur = (in_duration == '0) ? BEAT_BITS'(1) : in_duration;

  always_comb begin
    ins_sel   = '0;
    ins_found = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!slot_valid[i] && !ins_found) begin
        ins_sel[i] = 1'b1;
        ins_found  = 1'b1;
      end
    end
  end

  // Distance from the right edge: 1 at x = SCREEN_WIDTH-1, SCREEN_WIDTH at x = 0.
  assign q_in_range = CW'(x) < CW'(SCREEN_WIDTH);
  assign qd         = CW'(SCREEN_WIDTH) - CW'(x);
  assign qy         = CW'(y);

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    note_slot #(
      .NOTE_BITS       (NOTE_BITS),
      .BEAT_BITS       (BEAT_BITS),
      .CHANNEL_BITS    (CHANNEL_BITS),
      .ROW_HEIGHT      (ROW_HEIGHT),
      .PIXELS_PER_TICK (PIXELS_PER_TICK),
      .WINDOW_TICKS    (WINDOW_TICKS),
      .CW              (CW)
    ) u_slot (
      .clk           (clk),
      .reset         (reset),
      .clear         (clear),
      .tick          (tick),
      .load          (accept && ins_sel[gi]),
      .load_note     (in_note),
      .load_channel  (in_channel),
      .load_duration (load_dur),
      .qd            (qd),
      .qy            (qy),
      .q_in_range    (q_in_range),
      .valid         (slot_valid[gi]),
      .valid_next    (slot_valid_next[gi]),
      .channel       (slot_chan[gi]),
      .hit           (slot_hit[gi])
    );
  end

  always_comb begin
    occ_next = '0;
    for (int i = 0; i < SLOTS; i++) occ_next = occ_next + OCC_W'(slot_valid_next[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
      in_ready  <= 1'b1;
    end else begin
      occupancy <= occ_next;
      in_ready  <= occ_next < OCC_W'(SLOTS);
    end
  end

  // The winning channel is captured alongside the hit vector so that a slot
  // reloaded while the query is in flight cannot change the answer.
  always_comb begin
    win_ch = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (slot_hit[i]) win_ch = slot_chan[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      hit_q    <= '0;
      win_ch_q <= '0;
      on       <= 1'b0;
      channel  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], q_valid};
      hit_q    <= q_valid ? slot_hit : '0;
      win_ch_q <= q_valid ? win_ch : '0;
      on       <= vld_pipe[0] && (|hit_q);
      channel  <= (vld_pipe[0] && (|hit_q)) ? win_ch_q : '0;
    end
  end

  assign r_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_note_window.sv
// Bench for note_window: directed scenarios plus random traffic, every cycle
// compared against a slot-list reference model kept in plain integers.
module tb_note_window;
  localparam int SLOTS = 16;
  localparam int W     = 640;
  localparam int ROWH  = 30;
  localparam int WIN   = 160;
  localparam int AMAX  = 511;

  logic       clk = 1'b0;
  logic       reset = 1'b1, tick = 1'b0, in_valid = 1'b0, clear = 1'b0, q_valid = 1'b0;
  logic       in_ready, r_valid, on;
  logic [3:0] in_note = '0;
  logic [1:0] in_channel = '0, channel;
  logic [7:0] in_duration = '0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic [4:0] occupancy;

  int total = 0, bad = 0;

  // reference model state
  int m_v[SLOTS], m_note[SLOTS], m_ch[SLOTS], m_dur[SLOTS], m_age[SLOTS];
  int p1v = 0, p1on = 0, p1ch = 0, p2v = 0, p2on = 0, p2ch = 0;

  note_window dut (
    .clk(clk), .reset(reset), .tick(tick), .in_valid(in_valid), .in_ready(in_ready),
    .in_note(in_note), .in_channel(in_channel), .in_duration(in_duration), .clear(clear),
    .q_valid(q_valid), .x(x), .y(y), .r_valid(r_valid), .on(on), .channel(channel),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < SLOTS; i++) c += m_v[i];
    return c;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < SLOTS; i++) begin m_v[i] = 0; m_age[i] = 0; end
  endtask

  task automatic m_query(input int qx, input int qy, output int h, output int c);
    int d, lo;
    h = 0; c = 0;
    d = W - qx;
    for (int i = 0; i < SLOTS; i++) begin
      lo = (m_age[i] > m_dur[i]) ? m_age[i] - m_dur[i] : 0;
      if (m_v[i] && h == 0 && lo * 4 < d && d <= m_age[i] * 4 &&
          m_note[i] * ROWH <= qy && qy < (m_note[i] + 1) * ROWH) begin
        h = 1; c = m_ch[i];
      end
    end
  endtask

  // Advance model and DUT by one clock with the inputs currently driven.
  task automatic step();
    int qh, qc, idx;
    m_query(int'(x), int'(y), qh, qc);
    if (reset) begin
      m_clear();
      p1v = 0; p1on = 0; p1ch = 0; p2v = 0; p2on = 0; p2ch = 0;
    end else begin
      p2v = p1v; p2on = p1on; p2ch = p1ch;
      p1v = q_valid; p1on = q_valid && qh; p1ch = (q_valid && qh) ? qc : 0;
      if (clear) m_clear();
      else begin
        idx = -1;
        if (in_valid && m_count() < SLOTS)
          for (int i = SLOTS - 1; i >= 0; i--) if (!m_v[i]) idx = i;
        if (tick)
          for (int i = 0; i < SLOTS; i++) if (m_v[i]) begin
            m_age[i] = (m_age[i] + 1 > AMAX) ? AMAX : m_age[i] + 1;
            if (m_age[i] >= m_dur[i] + WIN) m_v[i] = 0;
          end
        if (idx >= 0) begin
          m_v[idx] = 1; m_age[idx] = 0; m_note[idx] = int'(in_note);
          m_ch[idx] = int'(in_channel);
          m_dur[idx] = (in_duration == 0) ? 1 : int'(in_duration);
        end
      end
    end
    @(posedge clk); #1;
    check("occ", int'(occupancy), m_count());
    check("rdy", int'(in_ready), (m_count() < SLOTS) ? 1 : 0);
    check("rv", int'(r_valid), p2v);
    check("on", int'(on), p2on);
    check("ch", int'(channel), p2ch);
  endtask

  task automatic idle();
    tick = 0; in_valid = 0; clear = 0; q_valid = 0; reset = 0;
    step();
  endtask

  task automatic do_reset();
    reset = 1; tick = 0; in_valid = 0; clear = 0; q_valid = 0;
    step();
    reset = 0;
  endtask

  task automatic ins(input int n, input int c, input int d, input int t);
    in_valid = 1; in_note = 4'(n); in_channel = 2'(c); in_duration = 8'(d); tick = t[0];
    step();
    in_valid = 0; tick = 0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin tick = 1; step(); end
    tick = 0;
  endtask

  // Query, then one idle cycle so the result is on the outputs afterwards.
  task automatic qry(input int qx, input int qy);
    q_valid = 1; x = 10'(qx); y = 9'(qy);
    step();
    q_valid = 0;
    step();
  endtask

  initial begin
    m_clear();
    for (int i = 0; i < SLOTS; i++) begin m_note[i] = 0; m_ch[i] = 0; m_dur[i] = 0; end
    do_reset();
    check("rst_rdy", int'(in_ready), 1);
    check("rst_occ", int'(occupancy), 0);

    // basic hit geometry
    ins(3, 2, 10, 0);
    ticks(5);
    qry(630, 100); check("tp1_on", int'(on), 1); check("tp1_ch", int'(channel), 2);
    qry(619, 100); check("tp1_left", int'(on), 0);
    qry(630, 125); check("tp1_row", int'(on), 0);

    // eviction at age = dur + 160
    do_reset();
    ins(1, 0, 10, 0);
    ticks(169);
    qry(2, 40); check("ev_on169", int'(on), 1);
    check("ev_occ1", int'(occupancy), 1);
    ticks(1);
    check("ev_occ0", int'(occupancy), 0);

    // full pool, refused insert, eviction frees the lowest slot
    do_reset();
    for (int i = 0; i < SLOTS; i++) ins(i, i % 4, (i == 5) ? 1 : 200, 0);
    check("full_rdy", int'(in_ready), 0);
    ins(7, 1, 5, 0);
    check("full_occ", int'(occupancy), 16);
    ticks(160);
    check("full_rdy160", int'(in_ready), 0);
    ticks(1);
    check("free_rdy", int'(in_ready), 1);
    ins(9, 3, 7, 0);
    check("refill_occ", int'(occupancy), 16);
    ticks(1);
    qry(639, 275); check("refill_ch", int'(channel), 3);

    // overlapping notes: lowest index wins
    do_reset();
    ins(2, 1, 1, 0);
    ins(2, 3, 50, 0);
    ticks(1);
    qry(638, 65); check("ovl_ch1", int'(channel), 1);
    ticks(160);
    qry(100, 65); check("ovl_on", int'(on), 1); check("ovl_ch3", int'(channel), 3);

    // tick together with insert; clear together with insert
    ins(2, 2, 20, 1);
    qry(639, 65); check("ti_on", int'(on), 0);
    clear = 1; in_valid = 1; step(); clear = 0; in_valid = 0;
    check("clr_occ", int'(occupancy), 0);

    // query stream across one row, reset in the middle
    do_reset();
    ins(5, 1, 30, 0);
    ticks(40);
    ins(5, 2, 10, 1);
    ticks(60);
    for (int xx = 0; xx < W; xx++) begin
      q_valid = 1; x = 10'(xx); y = 9'(160); reset = (xx == 320);
      step();
      if (xx == 320) check("mid_rst_rv", int'(r_valid), 0);
    end
    reset = 0;
    idle(); idle();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 599) == 0);
      clear       = ($urandom_range(0, 249) == 0);
      tick        = ($urandom_range(0, 2) == 0);
      in_valid    = ($urandom_range(0, 1) == 0);
      in_note     = 4'($urandom_range(0, 15));
      in_channel  = 2'($urandom_range(0, 3));
      in_duration = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 60));
      q_valid     = ($urandom_range(0, 3) != 0);
      x           = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(560, 639))
                                                 : 10'($urandom_range(0, 639));
      y           = 9'($urandom_range(0, 479));
      step();
    end
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/note_window.md
# note_window

Sequential, multi-channel successor to the combinational note-display stage. It owns a fixed pool of note slots. On every beat48 tick it ages each slot so the notes scroll right-to-left across the screen, and it evicts notes once they have fully left the screen. New notes enter through a valid/ready handshake. Per-pixel queries go through a 2-stage pipeline that returns a hit flag and the channel of the winning note to the pixel colouring stage.

## Interface
Parameters:
- SCREEN_WIDTH, 640, screen width in pixels
- SCREEN_HEIGHT, 480, screen height in pixels
- SCREEN_WIDTH_BITS, 10, width of x
- SCREEN_HEIGHT_BITS, 9, width of y
- SLOTS, 16, note slot capacity
- NOTE_BITS, 4, note index width; ROW_HEIGHT = SCREEN_HEIGHT >> NOTE_BITS (30)
- BEAT_BITS, 8, duration width in beat48 ticks
- PIXELS_PER_TICK, 4, horizontal scroll per tick; WINDOW_TICKS = SCREEN_WIDTH / PIXELS_PER_TICK (160)
- CHANNELS, 4, channel count; CHANNEL_BITS = clog2(CHANNELS)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle pulse per beat48 step
- in_valid  in  1  insertion request
- in_ready  out  1  a free slot exists
- in_note  in  NOTE_BITS  row of the new note
- in_channel  in  CHANNEL_BITS  channel of the new note
- in_duration  in  BEAT_BITS  length in ticks; 0 is treated as 1
- clear  in  1  invalidate all slots
- q_valid  in  1  pixel query strobe
- x  in  SCREEN_WIDTH_BITS  query x
- y  in  SCREEN_HEIGHT_BITS  query y
- r_valid  out  1  result strobe
- on  out  1  a note covers the queried pixel
- channel  out  CHANNEL_BITS  channel of the lowest-index covering slot; 0 when on=0
- occupancy  out  clog2(SLOTS+1)  count of valid slots

## Operation
- Each slot holds valid, note, channel, duration and age (BEAT_BITS+1 bits, saturating at all-ones).
- Insert: the transfer happens when in_valid && in_ready. The note goes into the lowest-index invalid slot with age=0. in_ready = occupancy < SLOTS. The insert is ignored when in_ready=0.
- Tick: every valid slot gets age+1.
  - After the increment, a slot with age >= duration + WINDOW_TICKS is invalidated in the same update.
  - Comparisons use BEAT_BITS+2 bits, so there is no overflow.
- Tick together with insert: the inserted slot is written with age=0 and is not aged that cycle. All other slots age normally.
- clear: invalidates all slots and has priority over tick and insert in the same cycle. reset does the same as clear and also zeroes the pipeline.
- Hit rule, for each valid slot:
  - Let d = SCREEN_WIDTH − x (range 1..SCREEN_WIDTH) and lo = max(age − duration, 0).
  - The slot hits iff lo·PIXELS_PER_TICK < d <= age·PIXELS_PER_TICK and note·ROW_HEIGHT <= y < (note+1)·ROW_HEIGHT.
  - A slot with age 0 never hits.
- Result: on = OR of the hits; channel comes from the lowest-index hitting slot.
- A query uses the slot state registered at the cycle q_valid is sampled. Updates in that same cycle are not visible to it.

## Timing
- Reset values: in_ready=1, r_valid=0, on=0, channel=0, occupancy=0, all slots invalid.
- Query latency is 2 cycles, fully pipelined with one query per cycle.
  - Stage 1 registers the per-slot hit vector.
  - Stage 2 registers on, channel and r_valid.
  - q_valid at cycle N gives r_valid at N+2.
- When r_valid=0, on and channel are 0.
- in_ready and occupancy are registered. They reflect inserts, evictions and clear from the previous cycle.
  - Two back-to-back inserts with a single free slot: the second is refused (in_ready=0 in the next cycle).
  - An eviction frees its slot from the next cycle on.
- Reset mid-query: in-flight results are dropped and r_valid=0 from the cycle after reset.
- Age saturation: age stays at all-ones, and eviction still fires because all-ones >= 255+160 is never reached for BEAT_BITS=8. Age width is therefore BEAT_BITS+1 with saturation, and eviction is guaranteed before saturation.

## Test plan
- Reset, then insert note 3, ch 2, dur 10, then 5 ticks; query (630,100) -> on=1, channel=2 after 2 cycles. Query (619,100) -> on=0. Query (630,125) -> on=0.
- Insert dur 10 then 170 ticks -> slot evicted at tick 170 (age 170 = 10+160), occupancy drops 1->0. Query (2,y in row) at tick 169 -> on=1.
- Fill 16 slots -> in_ready=0 and a 17th insert is ignored. Next tick evicts one slot -> in_ready=1 the following cycle, and a new insert lands in the lowest freed index.
- Overlap: slot 0 ch 1 and slot 1 ch 3, same note, same ages -> channel=1. Clear slot 0 by letting it expire earlier (dur 1) -> channel=3.
- Same-cycle tick+insert -> new slot age 0 (query at x=639 returns on=0), others aged by 1. clear+insert same cycle -> occupancy=0.
- Stream of queries on every cycle across one 640-pixel row with reset asserted mid-stream -> results match the model for each query, and r_valid=0 from the cycle after reset.
